// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB2 bridge.
//   htrans_e : AHB transfer types
//   hresp_e  : AHB response codes carried on the 2-bit hresp
//   state_e  : bridge FSM states
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ENABLE = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

endpackage

// File: rtl/apb_sel_decode.sv
// Slave-index decoder: maps an index to a one-hot APB select.
// Ports:
//   idx   in  IDX_W  slave index taken from the AHB address
//   sel   out NSLV   one-hot select (all zero when idx is out of range)
//   valid out 1      idx addresses an existing slave (idx < NSLV)
module apb_sel_decode #(
  parameter int unsigned NSLV  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx,
  output logic [NSLV-1:0]  sel,
  output logic             valid
);

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (32'(idx) == i) begin
        sel[i] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB2 master bridge. Every accepted NONSEQ/SEQ transfer
// becomes one SETUP/ENABLE access; AHB wait states cover the APB access.
// Addresses whose slave index is out of range get a two-cycle ERROR response.
// Ports:
//   pclk, presetn      clock, asynchronous active-low reset
//   hsel, haddr, htrans, hwrite, hwdata, hready_in   AHB slave inputs
//   hreadyout, hrdata, hresp                          AHB slave outputs
//   paddr, psel, penable, pwrite, pwdata              APB master outputs
//   prdata                                            APB read data (muxed externally)
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NSLV    = 3,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned SEL_LSB = 16
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            hsel,
  input  logic [31:0]     haddr,
  input  logic [1:0]      htrans,
  input  logic            hwrite,
  input  logic [31:0]     hwdata,
  input  logic            hready_in,
  output logic            hreadyout,
  output logic [31:0]     hrdata,
  output logic [1:0]      hresp,
  output logic [31:0]     paddr,
  output logic [NSLV-1:0] psel,
  output logic            penable,
  output logic            pwrite,
  output logic [31:0]     pwdata,
  input  logic [31:0]     prdata
);

  state_e            state;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [NSLV-1:0]   sel_dec;
  logic              sel_valid;
  // Write address/select parked here during WDATA so paddr/psel keep the
  // previous access's values until SETUP actually starts.
  logic [31:0]       addr_q;
  logic [NSLV-1:0]   sel_q;

  assign accept = hsel && hready_in &&
                  (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign idx    = haddr[SEL_LSB+IDX_W-1:SEL_LSB];

  apb_sel_decode #(
    .NSLV  (NSLV),
    .IDX_W (IDX_W)
  ) u_sel_decode (
    .idx   (idx),
    .sel   (sel_dec),
    .valid (sel_valid)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hrdata    <= '0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      addr_q    <= '0;
      sel_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            hreadyout <= 1'b0;
            if (!sel_valid) begin
              state <= ST_ERR1;
              hresp <= HRESP_ERROR;
            end else if (hwrite) begin
              state  <= ST_WDATA;
              addr_q <= haddr;
              sel_q  <= sel_dec;
            end else begin
              state  <= ST_SETUP;
              paddr  <= haddr;
              pwrite <= 1'b0;
              psel   <= sel_dec;
            end
          end
        end
        ST_WDATA: begin
          state  <= ST_SETUP;
          pwdata <= hwdata;
          paddr  <= addr_q;
          pwrite <= 1'b1;
          psel   <= sel_q;
        end
        ST_SETUP: begin
          state   <= ST_ENABLE;
          penable <= 1'b1;
        end
        ST_ENABLE: begin
          state     <= ST_IDLE;
          psel      <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
          if (!pwrite) hrdata <= prdata;
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
        end
        ST_ERR2: begin
          // A transfer presented alongside the error's ready cycle is dropped.
          state <= ST_IDLE;
          hresp <= HRESP_OKAY;
        end
        default: begin
          state     <= ST_IDLE;
          psel      <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule
